// File: rtl/fmap_pkg.sv
// ---------------------------------------------------------------------------
// fmap_pkg
// Shared definitions for the feature-map writer.
//   state_e     : controller states (IDLE, WRITE, DONE)
//   WORD_WIDTH  : width of one feature-map element and of the memory data bus
// ---------------------------------------------------------------------------
package fmap_pkg;

   localparam int WORD_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/fmap_writer.sv
// ---------------------------------------------------------------------------
// fmap_writer
// Captures a packed square feature map plus a base address, then streams the
// elements one per accepted write into a memory port at base+index.
//
// Parameters
//   map_width   side length of the square map (map_width*map_width elements)
//   addr_width  width of the write address (addresses wrap silently)
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-low reset
//   in_map     in   packed signed map, element i at [32*i+31:32*i]
//   in_valid   in   capture request, honoured only while in_ready is high
//   base_addr  in   address that element 0 is written to
//   in_ready   out  high only while idle
//   wr_en      out  write request
//   wr_addr    out  write address
//   wr_data    out  write data (signed)
//   wr_ready   in   memory accepts the write when wr_en && wr_ready
//   done       out  one-cycle pulse after the last write is accepted
//
// Build option
//   FMAP_WRITER_RELU_EN  when defined, negative elements are written as 0.
// ---------------------------------------------------------------------------
module fmap_writer
   import fmap_pkg::*;
#(
   parameter int map_width  = 3,
   parameter int addr_width = 8
) (
   input  logic                                         clk,
   input  logic                                         reset,
   input  logic [map_width*map_width*WORD_WIDTH-1:0]    in_map,
   input  logic                                         in_valid,
   input  logic [addr_width-1:0]                        base_addr,
   output logic                                         in_ready,
   output logic                                         wr_en,
   output logic [addr_width-1:0]                        wr_addr,
   output logic signed [WORD_WIDTH-1:0]                 wr_data,
   input  logic                                         wr_ready,
   output logic                                         done
);

   localparam int NUM_ELEMS = map_width * map_width;
   localparam int IDX_W     = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMS - 1);

   state_e                             state_q, state_d;
   logic [NUM_ELEMS*WORD_WIDTH-1:0]    map_q, map_d;
   logic [addr_width-1:0]              baseAddr_q, baseAddr_d;
   logic [IDX_W-1:0]                   idx_q, idx_d;
   logic [addr_width-1:0]              wrAddr_q, wrAddr_d;
   logic [WORD_WIDTH-1:0]              wrData_q, wrData_d;

   logic accept;
   logic lastAccept;

   // Optional ReLU applied to every element on its way into the data register.
   function automatic logic [WORD_WIDTH-1:0] shapeElem(input logic [WORD_WIDTH-1:0] e);
`ifdef FMAP_WRITER_RELU_EN
      return e[WORD_WIDTH-1] ? '0 : e;
`else
      return e;
`endif
   endfunction

   assign accept     = (state_q == WRITE) && wr_ready;
   assign lastAccept = accept && (idx_q == LAST_IDX);

   // State register: reset always lands in IDLE, aborting any sequence in flight.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: a capture only happens from IDLE, so in_valid seen in
   // WRITE or DONE is simply dropped rather than queued.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)   state_d = WRITE;
         WRITE:   if (lastAccept) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode: handshake signals depend on the state register only.
   always_comb begin
      in_ready = 1'b0;
      wr_en    = 1'b0;
      done     = 1'b0;
      case (state_q)
         IDLE:    in_ready = 1'b1;
         WRITE:   wr_en    = 1'b1;
         DONE:    done     = 1'b1;
         default: in_ready = 1'b0;
      endcase
   end

   // Datapath next-state: on capture the first address/element are loaded
   // straight from the inputs so wr_en can rise the very next cycle. On each
   // accepted, non-final write the index advances and the next address/element
   // are preloaded; a stalled write leaves everything untouched so the bus
   // holds stable.
   always_comb begin
      map_d      = map_q;
      baseAddr_d = baseAddr_q;
      idx_d      = idx_q;
      wrAddr_d   = wrAddr_q;
      wrData_d   = wrData_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               map_d      = in_map;
               baseAddr_d = base_addr;
               idx_d      = '0;
               wrAddr_d   = base_addr;
               wrData_d   = shapeElem(in_map[WORD_WIDTH-1:0]);
            end
         end
         WRITE: begin
            if (accept && !lastAccept) begin
               idx_d    = idx_q + 1'b1;
               wrAddr_d = baseAddr_q + addr_width'(idx_d);
               wrData_d = shapeElem(map_q[int'(idx_d)*WORD_WIDTH +: WORD_WIDTH]);
            end
         end
         default: begin
            idx_d = idx_q;
         end
      endcase
   end

   // Datapath registers: reset clears the bus outputs so nothing stale is
   // presented after an abort.
   always_ff @(posedge clk) begin
      if (!reset) begin
         map_q      <= '0;
         baseAddr_q <= '0;
         idx_q      <= '0;
         wrAddr_q   <= '0;
         wrData_q   <= '0;
      end else begin
         map_q      <= map_d;
         baseAddr_q <= baseAddr_d;
         idx_q      <= idx_d;
         wrAddr_q   <= wrAddr_d;
         wrData_q   <= wrData_d;
      end
   end

   assign wr_addr = wrAddr_q;
   assign wr_data = wrData_q;

endmodule

// File: tb/tb_fmap_writer.sv
// ---------------------------------------------------------------------------
// tb_fmap_writer
// Scoreboard bench for fmap_writer (map_width=3, addr_width=8). Stimulus
// pushes the expected writes (cycle, address, data) and done-pulse cycles into
// queues; a monitor on the falling edge pops and compares whenever the DUT
// presents a write or a done pulse.
// ---------------------------------------------------------------------------
module tb_fmap_writer;

   localparam int MW = 3;
   localparam int NE = MW * MW;
   localparam int AW = 8;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NE*32-1:0]     in_map;
   logic                 in_valid;
   logic [AW-1:0]        base_addr;
   logic                 in_ready;
   logic                 wr_en;
   logic [AW-1:0]        wr_addr;
   logic signed [31:0]   wr_data;
   logic                 wr_ready;
   logic                 done;

   fmap_writer #(
      .map_width  (MW),
      .addr_width (AW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_map    (in_map),
      .in_valid  (in_valid),
      .base_addr (base_addr),
      .in_ready  (in_ready),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_ready  (wr_ready),
      .done      (done)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Cycle counter: "cycle N" is the interval after the Nth rising edge.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;
   bit monOn = 1'b0;
   int t0;

   typedef struct {
      int          cyc;
      logic [7:0]  addr;
      logic [31:0] data;
   } exp_t;

   exp_t expQ[$];
   int   doneQ[$];

   // Single comparison point; every check goes through here.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
      end
   endtask

   function automatic logic [31:0] shaped(input logic [31:0] v);
`ifdef FMAP_WRITER_RELU_EN
      return v[31] ? 32'd0 : v;
`else
      return v;
`endif
   endfunction

   function automatic logic [NE*32-1:0] seqMap(input int first);
      logic [NE*32-1:0] m;
      m = '0;
      for (int i = 0; i < NE; i++) m[32*i +: 32] = 32'(first + i);
      return m;
   endfunction

   task automatic pushWrite(input int c, input logic [7:0] a, input logic [31:0] d);
      exp_t e;
      e.cyc  = c;
      e.addr = a;
      e.data = d;
      expQ.push_back(e);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, " in_ready"}, 32'(in_ready), 32'd1);
      checkOutput({tag, " wr_en"},    32'(wr_en),    32'd0);
      checkOutput({tag, " wr_addr"},  32'(wr_addr),  32'd0);
      checkOutput({tag, " wr_data"},  wr_data,       32'd0);
      checkOutput({tag, " done"},     32'(done),     32'd0);
   endtask

   // Monitor: every presented write is compared with the head of the queue;
   // while stalled the head is only peeked, which also proves the bus holds.
   always @(negedge clk) begin
      if (monOn) begin
         if (wr_en) begin
            if (expQ.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected write at cycle %0d: addr %0h data %0h, expected none",
                        cyc, wr_addr, wr_data);
            end else begin
               checkOutput("wr_addr", 32'(wr_addr), 32'(expQ[0].addr));
               checkOutput("wr_data", wr_data, expQ[0].data);
               if (wr_ready) begin
                  checkOutput("accept cycle", cyc, expQ[0].cyc);
                  void'(expQ.pop_front());
               end
            end
         end
         if (done) begin
            if (doneQ.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected done at cycle %0d: got 1, expected 0", cyc);
            end else begin
               checkOutput("done cycle", cyc, doneQ[0]);
               void'(doneQ.pop_front());
            end
         end
      end
   end

   // Drives one sequence starting in the current cycle (t0). Cycle k inputs:
   // wr_ready low inside [stallLo,stallHi], in_valid with an altered map at
   // busyAt, reset low at abortAt. in_ready is checked around readyAt.
   task automatic applyStimulus(input logic [NE*32-1:0] m, input logic [7:0] base,
                                input int stallLo, input int stallHi, input int busyAt,
                                input int abortAt, input int readyAt, input int nCyc);
      in_map    = m;
      base_addr = base;
      in_valid  = 1'b1;
      wr_ready  = 1'b1;
      reset     = 1'b1;
      for (int k = 1; k <= nCyc; k++) begin
         @(posedge clk);
         #1;
         in_valid = (k == busyAt);
         if (k == busyAt) in_map = ~m;
         wr_ready = !(k >= stallLo && k <= stallHi);
         reset    = !(k == abortAt);
         @(negedge clk);
         if (k == readyAt - 1) checkOutput("in_ready low", 32'(in_ready), 32'd0);
         if (k == readyAt)     checkOutput("in_ready high", 32'(in_ready), 32'd1);
         if (abortAt > 0 && k == abortAt + 1) checkResetOutputs("abort");
      end
      in_valid = 1'b0;
      wr_ready = 1'b1;
      reset    = 1'b1;
      checkOutput("write queue drained", 32'(expQ.size()), 32'd0);
      checkOutput("done queue drained", 32'(doneQ.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [NE*32-1:0] m;

      reset     = 1'b0;
      in_valid  = 1'b0;
      in_map    = '0;
      base_addr = '0;
      wr_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkResetOutputs("reset");
      reset = 1'b1;
      monOn = 1'b1;

      // Basic: elements 1..9 to 0x10..0x18 on cycles 1..9, done 10, ready 11.
      @(posedge clk); #1;
      t0 = cyc;
      for (int i = 0; i < NE; i++) pushWrite(t0 + 1 + i, 8'(8'h10 + i), 32'(i + 1));
      doneQ.push_back(t0 + 10);
      applyStimulus(seqMap(1), 8'h10, 0, -1, 0, 0, 11, 14);

      // Backpressure on cycles 3-5: element 3 held at 0x12, accepted at 6, done 13.
      @(posedge clk); #1;
      t0 = cyc;
      pushWrite(t0 + 1, 8'h10, 32'd1);
      pushWrite(t0 + 2, 8'h11, 32'd2);
      for (int i = 2; i < NE; i++) pushWrite(t0 + 4 + i, 8'(8'h10 + i), 32'(i + 1));
      doneQ.push_back(t0 + 13);
      applyStimulus(seqMap(1), 8'h10, 3, 5, 0, 0, 14, 17);

      // Negative data: element 0 = -5, element 8 = -1.
      @(posedge clk); #1;
      t0 = cyc;
      m = seqMap(1);
      m[31:0]       = 32'hFFFF_FFFB;
      m[32*8 +: 32] = 32'hFFFF_FFFF;
`ifdef FMAP_WRITER_RELU_EN
      pushWrite(t0 + 1, 8'h20, 32'h0000_0000);
`else
      pushWrite(t0 + 1, 8'h20, 32'hFFFF_FFFB);
`endif
      for (int i = 1; i < NE - 1; i++) pushWrite(t0 + 1 + i, 8'(8'h20 + i), 32'(i + 1));
      pushWrite(t0 + 9, 8'h28, shaped(32'hFFFF_FFFF));
      doneQ.push_back(t0 + 10);
      applyStimulus(m, 8'h20, 0, -1, 0, 0, 11, 14);

      // Address wrap: FE, FF, 00..06.
      @(posedge clk); #1;
      t0 = cyc;
      for (int i = 0; i < NE; i++) pushWrite(t0 + 1 + i, 8'(8'hFE + i), 32'(11 + i));
      doneQ.push_back(t0 + 10);
      applyStimulus(seqMap(11), 8'hFE, 0, -1, 0, 0, 11, 14);

      // Busy + abort: in_valid with new map at 4 is ignored, reset at 5 aborts.
      @(posedge clk); #1;
      t0 = cyc;
      for (int i = 0; i < 5; i++) pushWrite(t0 + 1 + i, 8'(8'h40 + i), 32'(21 + i));
      applyStimulus(seqMap(21), 8'h40, 0, -1, 4, 5, 6, 14);

      // Recovery after abort.
      @(posedge clk); #1;
      t0 = cyc;
      for (int i = 0; i < NE; i++) pushWrite(t0 + 1 + i, 8'(8'h80 + i), 32'(31 + i));
      doneQ.push_back(t0 + 10);
      applyStimulus(seqMap(31), 8'h80, 0, -1, 0, 0, 11, 14);

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fmap_writer.md
FMAP_WRITER -- requirements
Module: fmap_writer

Interface
REQ-001 The block SHALL have parameter map_width, default 3, giving the side length of the square feature map in elements.
REQ-002 The block SHALL have parameter addr_width, default 8, giving the width of the write address.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = in reset), sampled on the clk rising edge.
REQ-005 The block SHALL have port in_map, input, map_width*map_width*32 bits: packed signed map; element i occupies bits [32*i+31:32*i].
REQ-006 The block SHALL have port in_valid, input, 1 bit: requests capture of in_map and base_addr.
REQ-007 The block SHALL have port base_addr, input, addr_width bits: address that element 0 is written to.
REQ-008 The block SHALL have port in_ready, output, 1 bit: high only in IDLE.
REQ-009 The block SHALL have ports wr_en (output, 1 bit), wr_addr (output, addr_width bits) and wr_data (output, 32 bits, signed) forming the memory write port.
REQ-010 The block SHALL have port wr_ready, input, 1 bit: a write is accepted on a cycle where wr_en && wr_ready.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last write is accepted.

Function
REQ-012 The FSM SHALL have the states IDLE, WRITE and DONE.
- IDLE -> WRITE on in_valid && in_ready.
- WRITE -> DONE when element map_width*map_width-1 is accepted.
- DONE -> IDLE unconditionally after one cycle.
REQ-013 On capture, the block SHALL register in_map and base_addr and clear the element index to 0.
REQ-014 In WRITE, the block SHALL drive wr_en=1, wr_addr=base+idx and wr_data=element[idx], all from registers.
- wr_en rises the cycle after capture.
REQ-015 While wr_en && !wr_ready, wr_addr and wr_data SHALL hold stable and idx SHALL NOT advance.
REQ-016 When wr_ready is held high, the block SHALL sustain one accepted write per cycle.
REQ-017 wr_addr SHALL wrap modulo 2^addr_width, with no error flag.
REQ-018 If the last write is accepted at cycle M, done SHALL be 1 at M+1 only, and in_ready SHALL be 1 from M+2.
REQ-019 in_valid asserted outside IDLE SHALL be ignored, with no queuing.
REQ-020 in_map changing after capture SHALL have no effect on an in-progress write sequence.

Reset
REQ-021 While reset=0, the block SHALL force state IDLE and idx=0, and on the following edge the outputs SHALL be in_ready=1, wr_en=0, wr_addr=0, wr_data=0, done=0.
REQ-022 Reset asserted mid-WRITE SHALL abort the sequence with no further writes, and done SHALL NOT pulse.

Configuration
REQ-023 With FMAP_WRITER_RELU_EN defined, wr_data SHALL equal max(element, 0), clamping negative elements to 0.
REQ-024 Without FMAP_WRITER_RELU_EN, wr_data SHALL equal the captured element bit-exact.
- The FSM, latency and handshake are identical in both builds.

Structure
REQ-025 Shared package fmap_pkg SHALL hold the state enum (IDLE, WRITE, DONE) and the constant WORD_WIDTH=32.
REQ-026 The element index counter SHALL be $clog2(map_width*map_width) bits wide.
REQ-027 No sub-module is needed: element select, address add and the optional clamp SHALL be inline in fmap_writer.

Verification
REQ-028 Basic sequence: map_width=3, elements 1..9, base_addr=8'h10, wr_ready=1, in_valid pulse at cycle 0.
- Writes 1..9 to addresses 0x10..0x18 on cycles 1..9.
- done=1 at cycle 10; in_ready=1 at cycle 11.
REQ-029 Backpressure: as REQ-028 with wr_ready=0 on cycles 3-5.
- Address 0x12, data 3 held across cycles 3-5 and accepted at cycle 6.
- done=1 at cycle 13.
REQ-030 Negative data: element 0 = -5 (32'hFFFFFFFB).
- wr_data=32'hFFFFFFFB without the macro; wr_data=0 with FMAP_WRITER_RELU_EN.
REQ-031 Address wrap: base_addr=8'hFE with 9 elements gives addresses FE, FF, 00..06.
REQ-032 Busy and abort: in_valid pulsed at cycle 4 with a new in_map leaves the data stream unchanged; reset=0 at cycle 5 gives wr_en=0 from cycle 6, in_ready=1, and no done pulse.
